seven_seg_scan_decoder: RTL

Receive-side counterpart of the four-digit LED driver. Monitors the multiplexed active-low anode and segment lines and reconstructs the 16-bit hex word being displayed. Presents the word with a one-cycle valid strobe and flags illegal segment patterns and stalled scanning. Used for loopback self-check of the display path and as a bench monitor.

---
 rtl/seven_seg_scan_decoder.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan_decoder.sv
// Receive-side monitor for a four-digit multiplexed seven-segment display.
// Rebuilds the displayed 16-bit hex word from the active-low anode/segment lines.
module seven_seg_scan_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        an3,
    input  logic        an2,
    input  logic        an1,
    input  logic        an0,
    input  logic        a,
    input  logic        b,
    input  logic        c,
    input  logic        d,
    input  logic        e,
    input  logic        f,
    input  logic        g,
    output logic [15:0] word,
    output logic        word_valid,
    output logic        seg_error,
    output logic        frame_timeout
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);

    // Active-low segment pattern {a..g} to {legal, nibble}.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b0000001: r = {1'b1, 4'h0};
            7'b1001111: r = {1'b1, 4'h1};
            7'b0010010: r = {1'b1, 4'h2};
            7'b0000110: r = {1'b1, 4'h3};
            7'b1001100: r = {1'b1, 4'h4};
            7'b0100100: r = {1'b1, 4'h5};
            7'b0100000: r = {1'b1, 4'h6};
            7'b0001111: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0000100: r = {1'b1, 4'h9};
            7'b0001000: r = {1'b1, 4'hA};
            7'b1100000: r = {1'b1, 4'hB};
            7'b0110001: r = {1'b1, 4'hC};
            7'b1000010: r = {1'b1, 4'hD};
            7'b0110000: r = {1'b1, 4'hE};
            7'b0111000: r = {1'b1, 4'hF};
            default:    r = {1'b0, 4'h0};
        endcase
        return r;
    endfunction

    function automatic logic [1:0] anode_index(input logic [3:0] an_low);
        logic [1:0] r;
        case (an_low)
            4'b0001: r = 2'd0;
            4'b0010: r = 2'd1;
            4'b0100: r = 2'd2;
            4'b1000: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    logic [10:0]   sample_q, prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cap_q, cap_d;
    logic [3:0]    seen_q, seen_d;
    logic [15:0]   slots_q, slots_d;
    logic [15:0]   word_q, word_d;
    logic          word_valid_q, word_valid_d;
    logic          seg_error_q, seg_error_d;
    logic [TW-1:0] to_q, to_d;
    logic          timeout_q;

    logic [3:0]    an_low_s;
    logic          digit_sel_s;
    logic          same_s;
    logic          capture_s;
    logic [4:0]    dec_s;
    logic [1:0]    slot_idx_s;
    logic [3:0]    slot_bit_s;

    assign an_low_s    = ~sample_q[10:7];
    assign digit_sel_s = (an_low_s != 4'b0000) && ((an_low_s & (an_low_s - 4'd1)) == 4'b0000);
    assign same_s      = (sample_q == prev_q);

    // The count describes prev_q, so a capture decodes the sample that was stable.
    assign capture_s  = (cnt_q == CNT_MAX) && !cap_q;
    assign dec_s      = decode_seg(prev_q[6:0]);
    assign slot_idx_s = anode_index(~prev_q[10:7]);
    assign slot_bit_s = 4'b0001 << slot_idx_s;

    // Stability counter and once-per-dwell capture flag.
    always_comb begin
        cnt_d = cnt_q;
        cap_d = cap_q;
        if (digit_sel_s && same_s) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
            cap_d = capture_s ? 1'b1 : cap_q;
        end else begin
            cnt_d = digit_sel_s ? CW'(1) : CW'(0);
            cap_d = 1'b0;
        end
    end

    // Slot assembly, frame completion and illegal-pattern reporting.
    always_comb begin
        seen_d       = seen_q;
        slots_d      = slots_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        seg_error_d  = 1'b0;
        if (capture_s) begin
            if (dec_s[4]) begin
                slots_d[{slot_idx_s, 2'b00} +: 4] = dec_s[3:0];
                if ((seen_q | slot_bit_s) == 4'b1111) begin
                    word_d       = slots_d;
                    word_valid_d = 1'b1;
                    seen_d       = 4'b0000;
                end else begin
                    seen_d = seen_q | slot_bit_s;
                end
            end else begin
                seg_error_d = 1'b1;
            end
        end else begin
            seen_d = seen_q;
        end
    end

    // Frame watchdog, restarted by each delivered word.
    always_comb begin
        to_d = to_q;
        if (word_valid_q) begin
            to_d = TW'(0);
        end else if (to_q == TO_MAX) begin
            to_d = to_q;
        end else begin
            to_d = to_q + TW'(1);
        end
    end

    // State registers; the sample stage idles as blank (all ones).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_q     <= 11'h7FF;
            prev_q       <= 11'h7FF;
            cnt_q        <= CW'(0);
            cap_q        <= 1'b0;
            seen_q       <= 4'b0000;
            slots_q      <= 16'h0000;
            word_q       <= 16'h0000;
            word_valid_q <= 1'b0;
            seg_error_q  <= 1'b0;
            to_q         <= TW'(0);
            timeout_q    <= 1'b0;
        end else begin
            sample_q     <= {an3, an2, an1, an0, a, b, c, d, e, f, g};
            prev_q       <= sample_q;
            cnt_q        <= cnt_d;
            cap_q        <= cap_d;
            seen_q       <= seen_d;
            slots_q      <= slots_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            seg_error_q  <= seg_error_d;
            to_q         <= to_d;
            timeout_q    <= (to_d == TO_MAX);
        end
    end

    assign word          = word_q;
    assign word_valid    = word_valid_q;
    assign seg_error     = seg_error_q;
    assign frame_timeout = timeout_q;

endmodule
